// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: tile sequencer for the 4x4 int8 systolic GEMM datapath.
// Latches M/N/K on a start pulse and walks every 4x4 output tile: clears the
// array, streams A/B reads, waits out the drain, and writes back C rows.
// Optional macro SCHED_PERF_CNT_EN adds busy-cycle and write-stall counters.
module gemm_tile_scheduler #(
    parameter int DRAIN_CYCLES = 9,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        K,
    input  logic [7:0]        M,
    input  logic [7:0]        N,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] A_index,
    output logic [ADDR_W-1:0] B_index,
    output logic              feed_valid,
    output logic              sa_clear,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [1:0]        wb_row,
    output logic [ADDR_W-1:0] C_index
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1) + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_FEED, ST_DRAIN, ST_WB, ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           k_len_q, k_len_d;
    logic [7:0]           m_q, m_d;
    logic [7:0]           tm_tot_q, tm_tot_d;
    logic [7:0]           tn_tot_q, tn_tot_d;
    logic [7:0]           k_q, k_d;
    logic [7:0]           tm_q, tm_d;
    logic [7:0]           tn_q, tn_d;
    logic [1:0]           r_q, r_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;

    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]    a_index_q, a_index_d;
    logic [ADDR_W-1:0]    b_index_q, b_index_d;
    logic                 feed_valid_q, feed_valid_d;
    logic                 sa_clear_q, sa_clear_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [1:0]           wb_row_q, wb_row_d;
    logic [ADDR_W-1:0]    c_index_q, c_index_d;

    logic [8:0]           tm_sum, tn_sum;
    logic [9:0]           next_row;
    logic                 last_row, last_tile, last_k;

    assign tm_sum    = {1'b0, M} + 9'd3;
    assign tn_sum    = {1'b0, N} + 9'd3;
    assign next_row  = {tm_q, 2'b00} + {8'd0, r_q} + 10'd1;
    assign last_row  = (r_q == 2'd3) || (next_row >= {2'b00, m_q});
    assign last_tile = (tm_q == tm_tot_q - 8'd1) && (tn_q == tn_tot_q - 8'd1);
    assign last_k    = (k_q == k_len_q - 8'd1);

    // Next-state, loop counters and next values of every registered output.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d  = state_q;
        k_len_d  = k_len_q;
        m_d      = m_q;
        tm_tot_d = tm_tot_q;
        tn_tot_d = tn_tot_q;
        k_d      = k_q;
        tm_d     = tm_q;
        tn_d     = tn_q;
        r_d      = r_q;
        drain_d  = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    k_len_d  = K;
                    m_d      = M;
                    tm_tot_d = {1'b0, tm_sum[8:2]};
                    tn_tot_d = {1'b0, tn_sum[8:2]};
                    k_d      = 8'd0;
                    tm_d     = 8'd0;
                    tn_d     = 8'd0;
                    r_d      = 2'd0;
                    state_d  = (K == 8'd0 || M == 8'd0 || N == 8'd0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                k_d     = 8'd0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (last_k) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYCLES)) begin
                    r_d     = 2'd0;
                    state_d = ST_WB;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    if (!last_row) begin
                        r_d = r_q + 2'd1;
                    end else if (last_tile) begin
                        state_d = ST_DONE;
                    end else begin
                        r_d     = 2'd0;
                        state_d = ST_CLEAR;
                        if (tn_q == tn_tot_q - 8'd1) begin
                            tn_d = 8'd0;
                            tm_d = tm_q + 8'd1;
                        end else begin
                            tn_d = tn_q + 8'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        sa_clear_d   = (state_d == ST_CLEAR);
        rd_en_d      = (state_d == ST_FEED);
        wb_valid_d   = (state_d == ST_WB);
        feed_valid_d = rd_en_q;
        a_index_d    = rd_en_d ? ADDR_W'(k_d) * ADDR_W'(tm_tot_q) + ADDR_W'(tm_d) : '0;
        b_index_d    = rd_en_d ? ADDR_W'(k_d) * ADDR_W'(tn_tot_q) + ADDR_W'(tn_d) : '0;
        wb_row_d     = wb_valid_d ? r_d : 2'd0;
        c_index_d    = wb_valid_d ?
                       (ADDR_W'({tm_d, 2'b00}) + ADDR_W'(r_d)) * ADDR_W'(tn_tot_q) + ADDR_W'(tn_d)
                       : '0;
    end

    // State, counters and outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k_len_q      <= 8'd0;
            m_q          <= 8'd0;
            tm_tot_q     <= 8'd0;
            tn_tot_q     <= 8'd0;
            k_q          <= 8'd0;
            tm_q         <= 8'd0;
            tn_q         <= 8'd0;
            r_q          <= 2'd0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            a_index_q    <= '0;
            b_index_q    <= '0;
            feed_valid_q <= 1'b0;
            sa_clear_q   <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_row_q     <= 2'd0;
            c_index_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            k_len_q      <= k_len_d;
            m_q          <= m_d;
            tm_tot_q     <= tm_tot_d;
            tn_tot_q     <= tn_tot_d;
            k_q          <= k_d;
            tm_q         <= tm_d;
            tn_q         <= tn_d;
            r_q          <= r_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_en_q      <= rd_en_d;
            a_index_q    <= a_index_d;
            b_index_q    <= b_index_d;
            feed_valid_q <= feed_valid_d;
            sa_clear_q   <= sa_clear_d;
            wb_valid_q   <= wb_valid_d;
            wb_row_q     <= wb_row_d;
            c_index_q    <= c_index_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_en      = rd_en_q;
    assign A_index    = a_index_q;
    assign B_index    = b_index_q;
    assign feed_valid = feed_valid_q;
    assign sa_clear   = sa_clear_q;
    assign wb_valid   = wb_valid_q;
    assign wb_row     = wb_row_q;
    assign C_index    = c_index_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating job counters, cleared when a new job is accepted.
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (state_q == ST_IDLE && in_valid) begin
            perf_cycles_d = 32'd0;
            perf_stall_d  = 32'd0;
        end else begin
            if (busy_q && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
            if (state_q == ST_WB && !wb_ready && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: reference model fills read/write
// scoreboards per job, DUT activity is popped and compared cycle by cycle.
module tb_gemm_tile_scheduler;

    localparam int ADDR_W = 16;
    localparam int DRAIN  = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              wb_ready = 1'b0;
    logic [7:0]        K = 8'd0, M = 8'd0, N = 8'd0;
    logic              busy, done, rd_en, feed_valid, sa_clear, wb_valid;
    logic [ADDR_W-1:0] A_index, B_index, C_index;
    logic [1:0]        wb_row;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]       perf_cycles, perf_stall;
`endif

    gemm_tile_scheduler #(.DRAIN_CYCLES(DRAIN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .K(K), .M(M), .N(N),
        .busy(busy), .done(done), .rd_en(rd_en),
        .A_index(A_index), .B_index(B_index),
        .feed_valid(feed_valid), .sa_clear(sa_clear),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_row(wb_row), .C_index(C_index)
`ifdef SCHED_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int a; int b; } rd_t;
    typedef struct { int c; int row; } wr_t;
    typedef struct {
        int first_clear, n_clear, first_rd, last_rd, n_rd;
        int first_fv, last_fv, n_fv, first_wr, last_wr, n_wr;
        int done_cyc, n_not_busy;
    } stats_t;

    rd_t exp_rd[$];
    wr_t exp_wr[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed unexpected event, expected none", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job; the model fills the scoreboards, DUT traffic drains them.
    task automatic run_job(input int kk, input int mm, input int nn,
                           input int stall_n, input bit mid_iv, output stats_t st);
        int tm_tot, tn_tot, cyc, stall_left;
        bit holding;
        logic [ADDR_W-1:0] held_c;
        logic [1:0] held_row;
        rd_t ra;
        wr_t wa;
        tm_tot = (mm + 3) / 4;
        tn_tot = (nn + 3) / 4;
        exp_rd.delete();
        exp_wr.delete();
        if (kk != 0 && mm != 0 && nn != 0) begin
            for (int tm = 0; tm < tm_tot; tm++) begin
                for (int tn = 0; tn < tn_tot; tn++) begin
                    for (int k = 0; k < kk; k++) begin
                        ra.a = k * tm_tot + tm;
                        ra.b = k * tn_tot + tn;
                        exp_rd.push_back(ra);
                    end
                    for (int r = 0; r < 4; r++) begin
                        if (4 * tm + r < mm) begin
                            wa.c   = (4 * tm + r) * tn_tot + tn;
                            wa.row = r;
                            exp_wr.push_back(wa);
                        end
                    end
                end
            end
        end
        st.first_clear = -1; st.first_rd = -1; st.last_rd = -1; st.first_fv = -1;
        st.last_fv = -1; st.first_wr = -1; st.last_wr = -1; st.done_cyc = -1;
        st.n_clear = 0; st.n_rd = 0; st.n_fv = 0; st.n_wr = 0; st.n_not_busy = 0;

        K = 8'(kk); M = 8'(mm); N = 8'(nn);
        in_valid = 1'b1;
        wb_ready = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 1;
        stall_left = stall_n;
        holding = 1'b0;
        held_c = '0;
        held_row = 2'd0;
        while (cyc < 3000) begin
            if (busy !== 1'b1) st.n_not_busy++;
            if (sa_clear === 1'b1) begin
                if (st.first_clear < 0) st.first_clear = cyc;
                st.n_clear++;
            end
            if (rd_en === 1'b1) begin
                if (st.first_rd < 0) st.first_rd = cyc;
                st.last_rd = cyc;
                st.n_rd++;
                if (exp_rd.size() == 0) fail_now("extra_read");
                else begin
                    ra = exp_rd.pop_front();
                    check("A_index", A_index, ra.a);
                    check("B_index", B_index, ra.b);
                end
            end
            if (feed_valid === 1'b1) begin
                if (st.first_fv < 0) st.first_fv = cyc;
                st.last_fv = cyc;
                st.n_fv++;
            end
            in_valid = (mid_iv && cyc == 3);
            if (mid_iv && cyc == 3) begin M = 8'd8; N = 8'd8; K = 8'd1; end
            if (wb_valid === 1'b1) begin
                if (holding) begin
                    check("stall_C_index", C_index, held_c);
                    check("stall_wb_row", wb_row, held_row);
                end
                if (stall_left > 0) begin
                    wb_ready = 1'b0;
                    if (!holding) begin
                        holding = 1'b1;
                        held_c = C_index;
                        held_row = wb_row;
                    end
                    stall_left--;
                end else begin
                    wb_ready = 1'b1;
                    holding = 1'b0;
                    if (st.first_wr < 0) st.first_wr = cyc;
                    st.last_wr = cyc;
                    st.n_wr++;
                    if (exp_wr.size() == 0) fail_now("extra_write");
                    else begin
                        wa = exp_wr.pop_front();
                        check("C_index", C_index, wa.c);
                        check("wb_row", wb_row, wa.row);
                    end
                end
            end else begin
                wb_ready = 1'b1;
            end
            if (done === 1'b1) begin
                st.done_cyc = cyc;
                break;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        if (st.done_cyc < 0) fail_now("job_timeout");
        check("reads_left", exp_rd.size(), 0);
        check("writes_left", exp_wr.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_feed_valid"}, feed_valid, 0);
        check({tag, "_sa_clear"}, sa_clear, 0);
        check({tag, "_wb_valid"}, wb_valid, 0);
        check({tag, "_A_index"}, A_index, 0);
        check({tag, "_B_index"}, B_index, 0);
        check({tag, "_C_index"}, C_index, 0);
        check({tag, "_wb_row"}, wb_row, 0);
    endtask

    initial begin
        stats_t st;
        int activity;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
`ifdef SCHED_PERF_CNT_EN
        check("reset_perf_cycles", perf_cycles, 0);
        check("reset_perf_stall", perf_stall, 0);
`endif
        rst_n = 1'b1;
        step();

        // Single tile M=N=K=4, ready always high
        run_job(4, 4, 4, 0, 1'b0, st);
        check("t1_first_clear", st.first_clear, 1);
        check("t1_n_clear", st.n_clear, 1);
        check("t1_first_rd", st.first_rd, 2);
        check("t1_last_rd", st.last_rd, 5);
        check("t1_first_fv", st.first_fv, 3);
        check("t1_last_fv", st.last_fv, 6);
        check("t1_n_fv", st.n_fv, 4);
        check("t1_first_wr", st.first_wr, 16);
        check("t1_last_wr", st.last_wr, 19);
        check("t1_n_wr", st.n_wr, 4);
        check("t1_done_cyc", st.done_cyc, 20);
        check("t1_not_busy", st.n_not_busy, 0);
        step();
        check("t1_busy_after", busy, 0);
        check("t1_done_width", done, 0);
`ifdef SCHED_PERF_CNT_EN
        check("t1_perf_cycles", perf_cycles, 20);
        check("t1_perf_stall", perf_stall, 0);
`endif
        step();

        // Multi-tile M=5 N=8 K=2 with partial last row band
        run_job(2, 5, 8, 0, 1'b0, st);
        check("t2_n_clear", st.n_clear, 4);
        check("t2_n_rd", st.n_rd, 8);
        check("t2_n_wr", st.n_wr, 10);
        check("t2_done_cyc", st.done_cyc, 63);
        step();

        // Tall narrow shape M=8 N=3 K=3
        run_job(3, 8, 3, 0, 1'b0, st);
        check("t3_n_clear", st.n_clear, 2);
        check("t3_n_wr", st.n_wr, 8);
        step();

        // Zero K: immediate done, no traffic
        run_job(0, 4, 4, 0, 1'b0, st);
        check("t4_done_cyc", st.done_cyc, 1);
        check("t4_n_rd", st.n_rd, 0);
        check("t4_n_wr", st.n_wr, 0);
        check("t4_n_clear", st.n_clear, 0);
        step();

        // Write stall of 3 cycles on the first beat
        run_job(4, 4, 4, 3, 1'b0, st);
        check("t5_first_wr", st.first_wr, 19);
        check("t5_n_wr", st.n_wr, 4);
        check("t5_done_cyc", st.done_cyc, 23);
        step();
`ifdef SCHED_PERF_CNT_EN
        check("t5_perf_stall", perf_stall, 3);
        check("t5_perf_cycles", perf_cycles, 23);
`endif
        step();

        // Start pulse with other dimensions mid-job is ignored
        run_job(4, 4, 4, 0, 1'b1, st);
        check("t6_n_clear", st.n_clear, 1);
        check("t6_n_wr", st.n_wr, 4);
        check("t6_done_cyc", st.done_cyc, 20);
        step();

        // Reset pulsed during FEED of tile 0
        K = 8'd4; M = 8'd4; N = 8'd4;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("t7_rd_en_before_reset", rd_en, 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
`ifdef SCHED_PERF_CNT_EN
        check("midreset_perf_cycles", perf_cycles, 0);
`endif
        #2;
        rst_n = 1'b1;
        activity = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy !== 1'b0 || rd_en !== 1'b0 || wb_valid !== 1'b0 ||
                done !== 1'b0 || feed_valid !== 1'b0) activity++;
        end
        check("t7_quiet_after_reset", activity, 0);

        // Recovery job after reset
        run_job(1, 4, 4, 0, 1'b0, st);
        check("t8_n_wr", st.n_wr, 4);
        check("t8_done_cyc", st.done_cyc, 17);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
